// File: rtl/mvm_sequencer.sv
// mvm_sequencer: loads the matVecMult operand banks from a host word stream,
// holds them while the datapath computes, then streams the captured results out.
module mvm_sequencer #(
    parameter int BITS     = 8,
    parameter int MAT_R    = 8,
    parameter int MAT_C    = 4,
    parameter int TE       = 2,
    parameter int LATENCY  = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        start_vec_only,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [BITS-1:0]             wr_data,
    output logic [MAT_R*MAT_C*BITS-1:0] mv_mat,
    output logic [TE*MAT_C*BITS-1:0]    mv_vec,
    input  logic [TE*MAT_R*BITS-1:0]    mv_res,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [BITS-1:0]             rd_data,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_BITS-1:0]         cycle_count
);
    localparam int VEC_LEN = MAT_C;
    localparam int MAT_N   = MAT_R * MAT_C;
    localparam int VEC_N   = TE * VEC_LEN;
    localparam int RES_N   = TE * MAT_R;
    localparam int MAX_A   = (MAT_N > VEC_N) ? MAT_N : VEC_N;
    localparam int MAX_B   = (RES_N > LATENCY) ? RES_N : LATENCY;
    localparam int MAX_N   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int IDX_W   = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {IDLE, LOAD_MAT, LOAD_VEC, RUN, DRAIN} state_t;

    state_t                state, state_d;
    logic [IDX_W-1:0]      idx, idx_inc;
    logic                  wr_fire, rd_fire, last_rd;
    logic [MAT_N*BITS-1:0] mat_q;
    logic [VEC_N*BITS-1:0] vec_q;
    logic [RES_N*BITS-1:0] res_q;
    logic [BITS-1:0]       res_next;

    assign idx_inc = idx + IDX_W'(1);
    assign mv_mat  = mat_q;
    assign mv_vec  = vec_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        last_rd  = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (start)               state_d = LOAD_MAT;
                else if (start_vec_only) state_d = LOAD_VEC;
            end
            LOAD_MAT: begin
                wr_ready = 1'b1;
                if (wr_valid && idx == IDX_W'(MAT_N - 1)) state_d = LOAD_VEC;
            end
            LOAD_VEC: begin
                wr_ready = 1'b1;
                if (wr_valid && idx == IDX_W'(VEC_N - 1)) state_d = RUN;
            end
            RUN: begin
                if (idx == IDX_W'(LATENCY - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                rd_valid = 1'b1;
                last_rd  = (idx == IDX_W'(RES_N - 1));
                if (rd_ready && last_rd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        wr_fire = wr_valid && wr_ready;
        rd_fire = rd_valid && rd_ready;
    end

    // Look-ahead word so rd_data is already registered when the next read begins
    always_comb begin
        res_next = '0;
        for (int i = 0; i < RES_N; i++)
            if (idx_inc == IDX_W'(i)) res_next = res_q[i*BITS +: BITS];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            mat_q       <= '0;
            vec_q       <= '0;
            res_q       <= '0;
            rd_data     <= '0;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            done <= (state == DRAIN) && rd_fire && last_rd;

            // One index serves every phase; it restarts on each state change
            if (state_d != state)                          idx <= '0;
            else if (wr_fire || rd_fire || state == RUN)   idx <= idx_inc;

            for (int i = 0; i < MAT_N; i++)
                if (state == LOAD_MAT && wr_fire && idx == IDX_W'(i))
                    mat_q[i*BITS +: BITS] <= wr_data;
            for (int i = 0; i < VEC_N; i++)
                if (state == LOAD_VEC && wr_fire && idx == IDX_W'(i))
                    vec_q[i*BITS +: BITS] <= wr_data;

            if (state == RUN && state_d == DRAIN) begin
                res_q   <= mv_res;
                rd_data <= mv_res[BITS-1:0];
            end else if (rd_fire) begin
                rd_data <= last_rd ? '0 : res_next;
            end

            if (state == IDLE) begin
                if (start || start_vec_only) cycle_count <= '0;
            end else if (cycle_count != '1) begin
                cycle_count <= cycle_count + CNT_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_mvm_sequencer.sv
// Directed bench for mvm_sequencer: host word streams against a one-register
// behavioural matVecMult, with hand-computed results, timing and cycle counts.
`timescale 1ns/1ps
module tb_mvm_sequencer;
    logic         clock = 1'b0, reset = 1'b0;
    logic         start = 1'b0, start_vec_only = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
    logic [7:0]   wr_data = 8'h00;
    logic         wr_ready, rd_valid, busy, done;
    logic [7:0]   rd_data;
    logic [15:0]  cycle_count;
    logic [255:0] mv_mat;
    logic [63:0]  mv_vec;
    logic [127:0] mv_res;
    logic         wr_ready_s, rd_valid_s, busy_s, done_s;
    logic [7:0]   rd_data_s;
    logic [3:0]   cycle_count_s;
    logic [255:0] mv_mat_s;
    logic [63:0]  mv_vec_s;

    mvm_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .start_vec_only(start_vec_only),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .mv_mat(mv_mat), .mv_vec(mv_vec), .mv_res(mv_res),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    mvm_sequencer #(.CNT_BITS(4)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .start_vec_only(start_vec_only),
        .wr_valid(wr_valid), .wr_ready(wr_ready_s), .wr_data(wr_data),
        .mv_mat(mv_mat_s), .mv_vec(mv_vec_s), .mv_res(mv_res),
        .rd_valid(rd_valid_s), .rd_ready(rd_ready), .rd_data(rd_data_s),
        .busy(busy_s), .done(done_s), .cycle_count(cycle_count_s)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] matvec(input logic [255:0] m, input logic [63:0] v);
        logic [127:0]      r;
        logic signed [7:0] a, b;
        int                acc;
        r = '0;
        for (int t = 0; t < 2; t++)
            for (int row = 0; row < 8; row++) begin
                acc = 0;
                for (int c = 0; c < 4; c++) begin
                    a   = m[(row*4+c)*8 +: 8];
                    b   = v[(t*4+c)*8 +: 8];
                    acc = acc + a * b;
                end
                r[(t*8+row)*8 +: 8] = acc[7:0];
            end
        return r;
    endfunction

    logic [127:0] res_model;
    always_ff @(posedge clock) res_model <= matvec(mv_mat, mv_vec);
    assign mv_res = res_model;

    int           n_vec = 0, n_miss = 0;
    logic [7:0]   mat_words [32];
    logic [7:0]   vec_words [8];
    logic [7:0]   got [16];
    int           n_got, n_wr, done_cyc, hold_bad, hold_n;
    logic [15:0]  cc_done, cc_after_start;
    logic [3:0]   cc_s_done;
    logic         done_next, busy_after_start;
    logic [3:0]   snap_ctl;
    logic [7:0]   snap_rd;
    logic [15:0]  snap_cc;
    logic [255:0] snap_mat;
    logic [63:0]  snap_vec;

    // Stimulus driver only: records what it saw, scenarios do the checking
    task automatic run_job(input bit vec_only, input int wst, input int wlen,
                           input int rst_c, input int rlen, input int pulse_c, input int reset_c);
        bit         hold_armed, wfire, rfire;
        logic [7:0] hold_val;
        n_wr = 0; n_got = 0; done_cyc = -1; hold_bad = 0; hold_n = 0; hold_armed = 0;
        hold_val = '0; done_next = 1'bx; cc_done = 'x; cc_s_done = 'x;
        for (int i = 0; i < 16; i++) got[i] = 'x;
        start = !vec_only; start_vec_only = vec_only;
        @(posedge clock); #1;
        start = 1'b0; start_vec_only = 1'b0;
        cc_after_start = cycle_count; busy_after_start = busy;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == reset_c) begin
                reset = 1'b0; #1;
                snap_ctl = {wr_ready, rd_valid, busy, done};
                snap_rd = rd_data; snap_cc = cycle_count; snap_mat = mv_mat; snap_vec = mv_vec;
                wr_valid = 1'b0; rd_ready = 1'b0; start = 1'b0;
                @(posedge clock); #1;
                reset = 1'b1;
                return;
            end
            start    = (cyc == pulse_c);
            wr_valid = !(cyc >= wst && cyc < wst + wlen);
            if (vec_only) wr_data = (n_wr < 8) ? vec_words[n_wr] : 8'h00;
            else if (n_wr < 32) wr_data = mat_words[n_wr];
            else wr_data = (n_wr < 40) ? vec_words[n_wr-32] : 8'h00;
            rd_ready = !(cyc >= rst_c && cyc < rst_c + rlen);
            wfire = wr_valid && wr_ready;
            rfire = rd_valid && rd_ready;
            if (rd_valid && !rd_ready) begin
                if (hold_armed && rd_data !== hold_val) hold_bad++;
                hold_val = rd_data; hold_armed = 1; hold_n++;
            end else begin
                hold_armed = 0;
            end
            if (rfire && n_got < 16) got[n_got] = rd_data;
            if (rfire) n_got++;
            @(posedge clock); #1;
            if (wfire) n_wr++;
            if (done) begin
                done_cyc = cyc; cc_done = cycle_count; cc_s_done = cycle_count_s;
                break;
            end
        end
        wr_valid = 1'b0; rd_ready = 1'b0; start = 1'b0;
        @(posedge clock); #1;
        done_next = done;
    endtask

    task automatic fill_ones();
        for (int i = 0; i < 32; i++) mat_words[i] = 8'd1;
        for (int i = 0; i < 8; i++)  vec_words[i] = 8'd1;
    endtask

    task automatic test_reset();
        logic [255:0] act [8];
        string        nm [8];
        nm = '{"wr_ready", "rd_valid", "rd_data", "busy", "done", "cycle_count", "mv_mat", "mv_vec"};
        repeat (2) @(posedge clock);
        #1;
        act[0] = 256'(wr_ready); act[1] = 256'(rd_valid); act[2] = 256'(rd_data); act[3] = 256'(busy);
        act[4] = 256'(done); act[5] = 256'(cycle_count); act[6] = mv_mat; act[7] = 256'(mv_vec);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (act[i] !== '0) begin
                n_miss++; $display("FAIL reset_%s: got %h, want 0", nm[i], act[i]);
            end
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_full_ones();
        logic [255:0] exp_mat;
        exp_mat = {32{8'h01}};
        fill_ones();
        run_job(0, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got[i] !== 8'd4) begin n_miss++; $display("FAIL ones_res%0d: got %0d, want 4", i, got[i]); end
        end
        n_vec++; if (busy_after_start !== 1'b1) begin n_miss++; $display("FAIL ones_busy: got %b, want 1", busy_after_start); end
        n_vec++; if (n_wr != 40)       begin n_miss++; $display("FAIL ones_words: got %0d, want 40", n_wr); end
        n_vec++; if (done_cyc != 58)   begin n_miss++; $display("FAIL ones_done_cycle: got %0d, want 58", done_cyc); end
        n_vec++; if (cc_done !== 16'd58) begin n_miss++; $display("FAIL ones_count: got %0d, want 58", cc_done); end
        n_vec++; if (done_next !== 1'b0) begin n_miss++; $display("FAIL ones_done_width: got %b, want 0", done_next); end
        n_vec++; if (mv_mat !== exp_mat) begin n_miss++; $display("FAIL ones_mv_mat: got %h, want %h", mv_mat, exp_mat); end
        n_vec++; if (cc_s_done !== 4'd15) begin n_miss++; $display("FAIL ones_sat_count: got %0d, want 15", cc_s_done); end
    endtask

    task automatic test_alt_rows();
        logic [7:0] exp_res [16];
        exp_res = '{8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4,
                    8'd16, 8'd8, 8'd16, 8'd8, 8'd16, 8'd8, 8'd16, 8'd8};
        for (int i = 0; i < 32; i++) mat_words[i] = ((i / 4) % 2 == 0) ? 8'd2 : 8'd1;
        for (int i = 0; i < 8; i++)  vec_words[i] = (i < 4) ? 8'd1 : 8'd2;
        run_job(0, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got[i] !== exp_res[i]) begin n_miss++; $display("FAIL alt_res%0d: got %0d, want %0d", i, got[i], exp_res[i]); end
        end
        n_vec++; if (done_cyc != 58)     begin n_miss++; $display("FAIL alt_done_cycle: got %0d, want 58", done_cyc); end
        n_vec++; if (cc_done !== 16'd58) begin n_miss++; $display("FAIL alt_count: got %0d, want 58", cc_done); end
    endtask

    task automatic test_vec_only();
        logic [7:0] exp_res [16];
        exp_res = '{8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4,
                    8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4, 8'd8, 8'd4};
        for (int i = 0; i < 8; i++) vec_words[i] = 8'd1;
        run_job(1, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got[i] !== exp_res[i]) begin n_miss++; $display("FAIL vonly_res%0d: got %0d, want %0d", i, got[i], exp_res[i]); end
        end
        n_vec++; if (n_wr != 8)          begin n_miss++; $display("FAIL vonly_words: got %0d, want 8", n_wr); end
        n_vec++; if (done_cyc != 26)     begin n_miss++; $display("FAIL vonly_done_cycle: got %0d, want 26", done_cyc); end
        n_vec++; if (cc_done !== 16'd26) begin n_miss++; $display("FAIL vonly_count: got %0d, want 26", cc_done); end
        n_vec++; if (mv_mat[39:32] !== 8'd1) begin n_miss++; $display("FAIL vonly_mat_kept: got %0d, want 1", mv_mat[39:32]); end
    endtask

    task automatic test_stalls();
        fill_ones();
        run_job(0, 10, 3, 50, 5, -1, -1);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got[i] !== 8'd4) begin n_miss++; $display("FAIL stall_res%0d: got %0d, want 4", i, got[i]); end
        end
        n_vec++; if (done_cyc != 66)     begin n_miss++; $display("FAIL stall_done_cycle: got %0d, want 66", done_cyc); end
        n_vec++; if (cc_done !== 16'd66) begin n_miss++; $display("FAIL stall_count: got %0d, want 66", cc_done); end
        n_vec++; if (hold_n != 5)        begin n_miss++; $display("FAIL stall_valid_held: got %0d, want 5", hold_n); end
        n_vec++; if (hold_bad != 0)      begin n_miss++; $display("FAIL stall_data_held: got %0d changes, want 0", hold_bad); end
    endtask

    task automatic test_start_ignored_and_reset();
        fill_ones();
        run_job(0, 0, 0, 0, 0, 41, 50);
        n_vec++; if (n_got != 7) begin n_miss++; $display("FAIL ign_reads: got %0d, want 7", n_got); end
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if (got[i] !== 8'd4) begin n_miss++; $display("FAIL ign_res%0d: got %0d, want 4", i, got[i]); end
        end
        n_vec++; if (snap_ctl !== 4'b0)  begin n_miss++; $display("FAIL rst_ctl: got %b, want 0000", snap_ctl); end
        n_vec++; if (snap_rd !== 8'd0)   begin n_miss++; $display("FAIL rst_rd_data: got %0d, want 0", snap_rd); end
        n_vec++; if (snap_cc !== 16'd0)  begin n_miss++; $display("FAIL rst_count: got %0d, want 0", snap_cc); end
        n_vec++; if (snap_mat !== '0)    begin n_miss++; $display("FAIL rst_mv_mat: got %h, want 0", snap_mat); end
        n_vec++; if (snap_vec !== '0)    begin n_miss++; $display("FAIL rst_mv_vec: got %h, want 0", snap_vec); end
        run_job(1, 0, 0, 0, 0, -1, -1);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (got[i] !== 8'd0) begin n_miss++; $display("FAIL zero_res%0d: got %0d, want 0", i, got[i]); end
        end
        n_vec++; if (cc_done !== 16'd26) begin n_miss++; $display("FAIL zero_count: got %0d, want 26", cc_done); end
    endtask

    task automatic test_saturation();
        repeat (5) @(posedge clock);
        #1;
        n_vec++; if (cycle_count_s !== 4'd15) begin n_miss++; $display("FAIL sat_hold: got %0d, want 15", cycle_count_s); end
        n_vec++; if (cycle_count !== 16'd26)  begin n_miss++; $display("FAIL idle_hold: got %0d, want 26", cycle_count); end
        fill_ones();
        run_job(0, 0, 0, 0, 0, -1, -1);
        n_vec++; if (cc_after_start !== 16'd0) begin n_miss++; $display("FAIL sat_clear: got %0d, want 0", cc_after_start); end
        n_vec++; if (cc_s_done !== 4'd15)      begin n_miss++; $display("FAIL sat_job: got %0d, want 15", cc_s_done); end
        n_vec++; if (cc_done !== 16'd58)       begin n_miss++; $display("FAIL sat_wide: got %0d, want 58", cc_done); end
    endtask

    initial begin
        test_reset();
        test_full_ones();
        test_alt_rows();
        test_vec_only();
        test_stalls();
        test_start_ignored_and_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
